// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions and default widths for the data-port
// access sequencer.
package lc3b_types;

    localparam int LC3B_WIDTH      = 16;
    localparam int LC3B_ADDR_WIDTH = 16;
    localparam int LC3B_IND_LEVELS = 1;

    typedef enum logic [1:0] {
        IDLE,
        PTR,
        ACC,
        DONE
    } mem_seq_state_t;

endpackage

// File: rtl/byte_lane_steer.sv
// Write-mask and write-data shaping for the data port. A byte store is
// enabled on one lane, and its byte is copied onto every lane.
module byte_lane_steer #(
    parameter int WIDTH = 16
) (
    input  logic [$clog2(WIDTH/8)-1:0] lane,
    input  logic                       byte_en,
    input  logic                       write,
    input  logic [WIDTH-1:0]           data,
    output logic [WIDTH/8-1:0]         wmask,
    output logic [WIDTH-1:0]           wdata
);

    localparam int LANES = WIDTH / 8;

    // NOTE: every output gets a default first, so no path through this block infers a latch.
    always_comb begin
        wmask = '1;
        wdata = data;
        if (write && byte_en) begin
            wmask       = '0;
            wmask[lane] = 1'b1;
            wdata       = {LANES{data[7:0]}};
        end
    end

endmodule

// File: rtl/mem_access_seq.sv
// MEM-stage data-port sequencer. It performs optional pointer fetches and
// then the final read or write, stalling the pipeline until the result is held.
module mem_access_seq
    import lc3b_types::*;
#(
    parameter int WIDTH      = LC3B_WIDTH,
    parameter int ADDR_WIDTH = LC3B_ADDR_WIDTH,
    parameter int IND_LEVELS = LC3B_IND_LEVELS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic                  req_byte,
    input  logic                  req_indirect,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    input  logic                  advance,
    output logic                  stall,
    output logic                  done,
    output logic [WIDTH-1:0]      rdata,
    output logic [ADDR_WIDTH-1:0] final_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic [WIDTH/8-1:0]    mem_wmask,
    input  logic                  mem_resp,
    input  logic [WIDTH-1:0]      mem_rdata
);

    localparam int LANE_BITS = $clog2(WIDTH / 8);
    localparam int LVL_W     = (IND_LEVELS > 1) ? $clog2(IND_LEVELS) : 1;
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(IND_LEVELS - 1);

    mem_seq_state_t        state_q, state_d;
    logic [LVL_W-1:0]      lvl_q;
    logic                  write_q, byte_q;
    logic [ADDR_WIDTH-1:0] addr_q, final_addr_q;
    logic [WIDTH-1:0]      wdata_q, rdata_q;
    logic [WIDTH/8-1:0]    steer_wmask;
    logic [WIDTH-1:0]      steer_wdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid) state_d = req_indirect ? PTR : ACC;
            PTR:  if (mem_resp && lvl_q == LVL_LAST) state_d = ACC;
            ACC:  if (mem_resp) state_d = DONE;
            DONE: if (advance) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset too, because rdata and final_addr must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q        <= '0;
            write_q      <= 1'b0;
            byte_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            final_addr_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (req_valid) begin
                    write_q <= req_write;
                    byte_q  <= req_byte;
                    wdata_q <= req_wdata;
                    addr_q  <= req_addr;
                    lvl_q   <= '0;
                end
                PTR: if (mem_resp) begin
                    addr_q <= mem_rdata[ADDR_WIDTH-1:0];
                    if (lvl_q != LVL_LAST) lvl_q <= lvl_q + 1'b1;
                end
                ACC: if (mem_resp) begin
                    rdata_q      <= write_q ? '0 : mem_rdata;
                    final_addr_q <= addr_q;
                end
                default: ;
            endcase
        end
    end

    byte_lane_steer #(.WIDTH(WIDTH)) u_steer (
        .lane    (addr_q[LANE_BITS-1:0]),
        .byte_en (byte_q),
        .write   (write_q),
        .data    (wdata_q),
        .wmask   (steer_wmask),
        .wdata   (steer_wdata)
    );

    // Port strobes depend on registered state only; idle port outputs are all zero.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        mem_wmask   = '0;
        unique case (state_q)
            PTR: begin
                mem_read    = 1'b1;
                mem_address = addr_q;
                mem_wmask   = '1;
            end
            ACC: begin
                mem_read    = !write_q;
                mem_write   = write_q;
                mem_address = addr_q;
                mem_wdata   = steer_wdata;
                mem_wmask   = steer_wmask;
            end
            default: ;
        endcase
    end

    assign done       = (state_q == DONE);
    assign stall      = req_valid && !done;
    assign rdata      = rdata_q;
    assign final_addr = final_addr_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: one instance with a single pointer
// level and one with three, sharing stimulus and a simple memory responder.
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0, req_indirect = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        advance = 1'b0;
    logic        mem_resp = 1'b0;
    logic [15:0] mem_rdata = '0;

    logic        stall1, done1, rd1, wr1;
    logic [15:0] rdata1, final1, addr1, wdata1;
    logic [1:0]  wmask1;
    logic        stall3, done3, rd3, wr3;
    logic [15:0] rdata3, final3, addr3, wdata3;
    logic [1:0]  wmask3;

    int checks = 0;
    int errors = 0;

    logic        sel3 = 1'b0;
    int          wait_cfg = 0;
    int          wcnt = 0;
    logic        resp_force = 1'b0;
    logic [15:0] mem_img [logic [15:0]];
    logic        strobe_sel;
    logic [15:0] addr_sel;

    always #5 clk = ~clk;

    mem_access_seq #(.WIDTH(16), .ADDR_WIDTH(16), .IND_LEVELS(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_byte(req_byte), .req_indirect(req_indirect), .req_addr(req_addr),
        .req_wdata(req_wdata), .advance(advance), .stall(stall1), .done(done1),
        .rdata(rdata1), .final_addr(final1), .mem_read(rd1), .mem_write(wr1),
        .mem_address(addr1), .mem_wdata(wdata1), .mem_wmask(wmask1),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    mem_access_seq #(.WIDTH(16), .ADDR_WIDTH(16), .IND_LEVELS(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_byte(req_byte), .req_indirect(req_indirect), .req_addr(req_addr),
        .req_wdata(req_wdata), .advance(advance), .stall(stall3), .done(done3),
        .rdata(rdata3), .final_addr(final3), .mem_read(rd3), .mem_write(wr3),
        .mem_address(addr3), .mem_wdata(wdata3), .mem_wmask(wmask3),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    // Memory responder: answers the selected instance after wait_cfg idle strobe cycles.
    always begin
        @(posedge clk);
        #1;
        strobe_sel = sel3 ? (rd3 | wr3) : (rd1 | wr1);
        addr_sel   = sel3 ? addr3 : addr1;
        if (strobe_sel && wcnt == wait_cfg) begin
            mem_resp  = 1'b1;
            mem_rdata = mem_img.exists(addr_sel) ? mem_img[addr_sel] : 16'h0000;
            wcnt      = 0;
        end else begin
            mem_resp  = 1'b0;
            mem_rdata = 16'hDEAD;
            wcnt      = strobe_sel ? wcnt + 1 : 0;
        end
        if (resp_force) mem_resp = 1'b1;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic w, input logic b, input logic ind,
                             input logic [15:0] a, input logic [15:0] d);
        req_valid = 1'b1; req_write = w; req_byte = b; req_indirect = ind;
        req_addr = a; req_wdata = d;
    endtask

    task automatic release_req();
        next_cycle(); advance = 1'b1;
        next_cycle(); advance = 1'b0; req_valid = 1'b0;
    endtask

    task automatic do_reset();
        next_cycle(); rst = 1'b1; req_valid = 1'b0; advance = 1'b0;
        next_cycle(); rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({stall1, done1, rd1, wr1, rdata1, final1, addr1, wdata1, wmask1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: got stall=%b done=%b rd=%b wr=%b rdata=%h fa=%h addr=%h wd=%h wm=%b, want all 0",
                     stall1, done1, rd1, wr1, rdata1, final1, addr1, wdata1, wmask1);
        end
        checks++;
        if ({stall3, done3, rd3, wr3, rdata3, final3, addr3, wdata3, wmask3} !== '0) begin
            errors++;
            $display("FAIL reset_dut3: got stall=%b done=%b rd=%b wr=%b rdata=%h fa=%h addr=%h wd=%h wm=%b, want all 0",
                     stall3, done3, rd3, wr3, rdata3, final3, addr3, wdata3, wmask3);
        end
    endtask

    task automatic test_direct_ldr();
        sel3 = 1'b0; wait_cfg = 0;
        next_cycle(); drive_req(1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000);
        @(negedge clk);
        checks++;
        if (stall1 !== 1'b1) begin errors++; $display("FAIL ldr_stall_c0: got %b, want 1", stall1); end
        next_cycle(); @(negedge clk);
        checks++;
        if ({rd1, wr1, addr1, stall1} !== {1'b1, 1'b0, 16'h1000, 1'b1}) begin
            errors++;
            $display("FAIL ldr_strobe_c1: got rd=%b wr=%b addr=%h stall=%b, want rd=1 wr=0 addr=1000 stall=1", rd1, wr1, addr1, stall1);
        end
        next_cycle(); @(negedge clk);
        checks++;
        if ({done1, stall1, rd1, rdata1, final1} !== {1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h1000}) begin
            errors++;
            $display("FAIL ldr_done_c2: got done=%b stall=%b rd=%b rdata=%h fa=%h, want 1 0 0 beef 1000", done1, stall1, rd1, rdata1, final1);
        end
        release_req();
    endtask

    task automatic test_stb();
        next_cycle(); drive_req(1'b1, 1'b1, 1'b0, 16'h2003, 16'h12AB);
        next_cycle(); @(negedge clk);
        checks++;
        if ({rd1, wr1, addr1, wmask1, wdata1} !== {1'b0, 1'b1, 16'h2003, 2'b10, 16'hABAB}) begin
            errors++;
            $display("FAIL stb_strobe: got rd=%b wr=%b addr=%h wm=%b wd=%h, want 0 1 2003 10 abab", rd1, wr1, addr1, wmask1, wdata1);
        end
        next_cycle(); @(negedge clk);
        checks++;
        if ({done1, rdata1, final1} !== {1'b1, 16'h0000, 16'h2003}) begin
            errors++;
            $display("FAIL stb_done: got done=%b rdata=%h fa=%h, want 1 0000 2003", done1, rdata1, final1);
        end
        release_req();
    endtask

    task automatic test_ldi();
        next_cycle(); drive_req(1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000);
        next_cycle(); @(negedge clk);
        checks++;
        if ({rd1, wr1, addr1} !== {1'b1, 1'b0, 16'h3000}) begin
            errors++; $display("FAIL ldi_ptr: got rd=%b wr=%b addr=%h, want 1 0 3000", rd1, wr1, addr1);
        end
        next_cycle(); @(negedge clk);
        checks++;
        if ({rd1, wr1, addr1, done1} !== {1'b1, 1'b0, 16'h4000, 1'b0}) begin
            errors++; $display("FAIL ldi_acc: got rd=%b wr=%b addr=%h done=%b, want 1 0 4000 0", rd1, wr1, addr1, done1);
        end
        next_cycle(); @(negedge clk);
        checks++;
        if ({done1, rdata1, final1} !== {1'b1, 16'h5555, 16'h4000}) begin
            errors++; $display("FAIL ldi_done_c3: got done=%b rdata=%h fa=%h, want 1 5555 4000", done1, rdata1, final1);
        end
        release_req();
    endtask

    task automatic test_sti_three_levels();
        int rd_cnt = 0, wr_cnt = 0, both = 0;
        do_reset();
        sel3 = 1'b1; wait_cfg = 2;
        next_cycle(); drive_req(1'b1, 1'b0, 1'b1, 16'h6000, 16'hCAFE);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            next_cycle(); @(negedge clk);
            if (rd3 && mem_resp) rd_cnt++;
            if (wr3 && mem_resp) wr_cnt++;
            if (rd3 && wr3) both++;
            if (cyc == 10) begin
                checks++;
                if ({rd3, wr3, addr3, wmask3, wdata3} !== {1'b0, 1'b1, 16'h6300, 2'b11, 16'hCAFE}) begin
                    errors++;
                    $display("FAIL sti_write_c10: got rd=%b wr=%b addr=%h wm=%b wd=%h, want 0 1 6300 11 cafe", rd3, wr3, addr3, wmask3, wdata3);
                end
            end
            if (cyc == 12) begin
                checks++;
                if ({done3, stall3} !== 2'b01) begin
                    errors++; $display("FAIL sti_not_done_c12: got done=%b stall=%b, want 0 1", done3, stall3);
                end
            end
        end
        next_cycle(); @(negedge clk);
        checks++;
        if ({done3, rdata3, final3} !== {1'b1, 16'h0000, 16'h6300}) begin
            errors++; $display("FAIL sti_done_c13: got done=%b rdata=%h fa=%h, want 1 0000 6300", done3, rdata3, final3);
        end
        checks++;
        if (rd_cnt != 3 || wr_cnt != 1 || both != 0) begin
            errors++; $display("FAIL sti_counts: got reads=%0d writes=%0d overlap=%0d, want 3 1 0", rd_cnt, wr_cnt, both);
        end
        release_req();
        sel3 = 1'b0; wait_cfg = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        next_cycle(); drive_req(1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000);
        next_cycle();
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({done1, stall1, rd1, rdata1, final1} !== {1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h1000}) begin
                errors++;
                $display("FAIL hold_%0d: got done=%b stall=%b rd=%b rdata=%h fa=%h, want 1 0 0 beef 1000", i, done1, stall1, rd1, rdata1, final1);
            end
            next_cycle(); req_addr = 16'h2222; req_indirect = 1'b1;
        end
        advance = 1'b1;
        next_cycle(); advance = 1'b0; drive_req(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000);
        @(negedge clk);
        checks++;
        if ({done1, stall1, rd1, wr1} !== 4'b0100) begin
            errors++; $display("FAIL b2b_idle: got done=%b stall=%b rd=%b wr=%b, want 0 1 0 0", done1, stall1, rd1, wr1);
        end
        next_cycle(); @(negedge clk);
        checks++;
        if ({rd1, addr1} !== {1'b1, 16'h3000}) begin
            errors++; $display("FAIL b2b_strobe: got rd=%b addr=%h, want 1 3000", rd1, addr1);
        end
        next_cycle(); @(negedge clk);
        checks++;
        if ({done1, rdata1, final1} !== {1'b1, 16'h4000, 16'h3000}) begin
            errors++; $display("FAIL b2b_done: got done=%b rdata=%h fa=%h, want 1 4000 3000", done1, rdata1, final1);
        end
        release_req();
    endtask

    task automatic test_reset_mid_ptr();
        next_cycle(); drive_req(1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000);
        next_cycle(); rst = 1'b1; resp_force = 1'b1;
        @(negedge clk);
        checks++;
        if ({rd1, addr1, mem_resp} !== {1'b1, 16'h3000, 1'b1}) begin
            errors++; $display("FAIL rstptr_c1: got rd=%b addr=%h resp=%b, want 1 3000 1", rd1, addr1, mem_resp);
        end
        next_cycle(); rst = 1'b0; resp_force = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall1, done1, rd1, wr1, rdata1, final1, addr1, wdata1, wmask1} !== '0) begin
            errors++;
            $display("FAIL rstptr_zero: got stall=%b done=%b rd=%b wr=%b rdata=%h fa=%h addr=%h wd=%h wm=%b, want all 0",
                     stall1, done1, rd1, wr1, rdata1, final1, addr1, wdata1, wmask1);
        end
        next_cycle(); drive_req(1'b0, 1'b0, 1'b0, 16'h1000, 16'h0000);
        next_cycle(); @(negedge clk);
        checks++;
        if ({rd1, addr1} !== {1'b1, 16'h1000}) begin
            errors++; $display("FAIL rstptr_new_strobe: got rd=%b addr=%h, want 1 1000", rd1, addr1);
        end
        next_cycle(); @(negedge clk);
        checks++;
        if ({done1, rdata1, final1} !== {1'b1, 16'hBEEF, 16'h1000}) begin
            errors++; $display("FAIL rstptr_new_done: got done=%b rdata=%h fa=%h, want 1 beef 1000", done1, rdata1, final1);
        end
        release_req();
    endtask

    initial begin
        mem_img[16'h1000] = 16'hBEEF;
        mem_img[16'h3000] = 16'h4000;
        mem_img[16'h4000] = 16'h5555;
        mem_img[16'h6000] = 16'h6100;
        mem_img[16'h6100] = 16'h6200;
        mem_img[16'h6200] = 16'h6300;
        test_reset();
        test_direct_ldr();
        test_stb();
        test_ldi();
        test_sti_three_levels();
        test_back_to_back();
        test_reset_mid_ptr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Parametrised data-port access sequencer for the MEM stage of the pipelined LC-3b core. It accepts one memory request per instruction, performs an optional chain of pointer fetches (LDI/STI generalised to N levels), then the final word or byte read or write. It drives stall back to the hazard/stall controller until the result is ready, and holds the result until the pipeline advances. It replaces the toggle-based LDI/STI stall logic and the separate MDR/address muxing on data port b.

## Interface
Parameters:
- WIDTH, 16, data word width in bits; multiple of 8, at least 16
- ADDR_WIDTH, 16, address width in bits
- IND_LEVELS, 1, pointer fetches per indirect request; range 1..4

Ports:
- clk  in  1  clock; everything samples on the rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  MEM-stage instruction needs a data access (read_memory | write_memory)
- req_write  in  1  final access is a write
- req_byte  in  1  final access is byte-wide (LDB/STB)
- req_indirect  in  1  perform IND_LEVELS pointer fetches first (LDI/STI)
- req_addr  in  ADDR_WIDTH  effective address from the EX stage
- req_wdata  in  WIDTH  store data; for byte stores, the byte is in [7:0]
- advance  in  1  pipeline registers load this cycle (load_register)
- stall  out  1  req_valid & !done; the pipeline must not advance
- done  out  1  access complete; rdata and final_addr are valid
- rdata  out  WIDTH  word returned by the final read; 0 after a write
- final_addr  out  ADDR_WIDTH  address used by the final access
- mem_read  out  1  data-port read strobe
- mem_write  out  1  data-port write strobe
- mem_address  out  ADDR_WIDTH  data-port address
- mem_wdata  out  WIDTH  data-port write data
- mem_wmask  out  WIDTH/8  byte write enables
- mem_resp  in  1  data-port response; completes the current strobe this cycle
- mem_rdata  in  WIDTH  read data, valid when mem_resp is high

## Operation
- States:
  - IDLE: no access in progress.
  - PTR: pointer fetch.
  - ACC: final access.
  - DONE: result held for the pipeline.
- IDLE, req_valid=1: latch write, byte, wdata and addr into addr_q. Go to PTR with lvl_q=0 if req_indirect, otherwise go to ACC.
- IDLE, req_valid=0: stay in IDLE; stall=0.
- PTR:
  - Drive mem_read=1 with mem_address=addr_q.
  - On mem_resp: addr_q←mem_rdata[ADDR_WIDTH-1:0].
  - If lvl_q==IND_LEVELS-1, go to ACC; otherwise lvl_q++ and stay in PTR.
- ACC:
  - Drive mem_read=!write_q and mem_write=write_q, with mem_address=addr_q.
  - On mem_resp: rdata_q←(write_q ? 0 : mem_rdata), final_addr←addr_q, go to DONE.
- DONE:
  - done=1 and stall=0.
  - On advance, go to IDLE. Otherwise hold rdata, final_addr and done indefinitely.
- Write shaping:
  - Word writes: mem_wmask all ones; mem_wdata=wdata_q.
  - Byte writes: mem_wmask one-hot at lane addr_q[log2(WIDTH/8)-1:0]; mem_wdata is wdata_q[7:0] replicated across all lanes.
  - Reads: mem_wmask all ones.
- Reads always return the full word. Byte extraction stays in WB.
- Request fields are sampled only in IDLE. Changes to req_* during PTR, ACC or DONE are ignored.
- advance outside DONE is ignored.
- mem_read and mem_write are never high together. Both are 0 in IDLE and DONE.

## Timing
- Reset values:
  - State is IDLE; lvl_q is 0.
  - All outputs are 0: done, stall-contribution, rdata, final_addr, mem_read, mem_write, mem_address, mem_wdata and mem_wmask.
- Reset mid-operation:
  - The strobe drops in the cycle after rst is sampled.
  - Any mem_resp in that cycle is ignored.
  - The sequence is abandoned.
- Strobes are Moore outputs, registered state only. The memory interface has no combinational path from mem_resp.
- stall is combinational from req_valid and state.
- Latency, counted from the req_valid cycle in IDLE (cycle 0) to done, with the memory answering in the first strobe cycle:
  - Direct access: done at cycle 2.
  - Indirect access: done at cycle 2+IND_LEVELS.
  - Each wait cycle on mem_resp adds 1.
- Back-to-back requests: advance in DONE (cycle n) gives IDLE at n+1. The new request is sampled at n+1 and its strobe starts at n+2.
- lvl_q is wide enough for IND_LEVELS-1 and never wraps; the bound is checked against IND_LEVELS-1.

## Structure
- Add the following to lc3b_types:
  - The mem_seq_state_t enum (IDLE, PTR, ACC, DONE).
  - Default width constants.
- Sub-module byte_lane_steer, purely combinational: takes WIDTH, addr LSBs, byte flag, write flag and data, and returns wmask and wdata.
- Top level: FSM, lvl counter, and the addr_q / wdata_q / rdata_q / final_addr registers.

## Test plan
- Direct LDR: req_addr=0x1000, mem_resp in the first strobe cycle with rdata 0xBEEF → mem_read high at cycle 1 with address 0x1000. done at cycle 2 with rdata=0xBEEF and final_addr=0x1000. stall high for cycles 0–1.
- STB to 0x2003, wdata=0x12AB → mem_write with address 0x2003, wmask=2'b10, wdata=0xABAB; done with rdata=0.
- LDI with IND_LEVELS=1: pointer at 0x3000 returns 0x4000, data returns 0x5555 → PTR read at 0x3000, then ACC read at 0x4000. done at cycle 3 with rdata=0x5555.
- IND_LEVELS=3, STI with 2 wait cycles per access → exactly 3 pointer reads, then a write. done at cycle 2+3+8. mem_read and mem_write never both high.
- Hold and back-to-back: hold advance=0 for 5 cycles in DONE → outputs stable. Then advance with a new req_valid → the next strobe starts 2 cycles after advance.
- Reset mid-PTR with mem_resp high in the reset cycle → no state update; all outputs 0 the next cycle; a new request then completes normally.
